// File: rtl/mem_wb_pkg.sv
// Shared types and width defaults for the MEM/WB pipeline register.
package mem_wb_pkg;

  localparam int DATA_W_DEF     = 32;
  localparam int REG_ADDR_W_DEF = 5;
  localparam int MISS_CNT_W     = 8;

  typedef enum logic {
    IDLE      = 1'b0,
    MISS_WAIT = 1'b1
  } missState_t;

  // Record held by one pipeline slot at the default widths; the top declares
  // the same layout at its own parameterised widths.
  typedef struct packed {
    logic                      valid;
    logic                      hit;
    logic [DATA_W_DEF-1:0]     readData;
    logic [DATA_W_DEF-1:0]     aluResult;
    logic [REG_ADDR_W_DEF-1:0] writeReg;
    logic                      regWrite;
    logic                      memToReg;
  } memWbSlot_t;

endpackage

// File: rtl/mem_wb_slot.sv
// One MEM/WB slot register: async reset, flush clears valid/regWrite, stall holds.
module mem_wb_slot
  import mem_wb_pkg::*;
#(
  parameter type slot_t = memWbSlot_t
) (
  input  logic  clockPulse,
  input  logic  reset,
  input  logic  clear,
  input  logic  load,
  input  slot_t d,
  output slot_t q
);

  // NOTE: state is updated with non-blocking assignments so every slot samples
  // its neighbour's pre-edge value and the chain shifts by exactly one place.
  always_ff @(posedge clockPulse or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (clear) begin
      q.valid    <= 1'b0;
      q.regWrite <= 1'b0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/mem_wb_pipe_reg.sv
// Parametrised MEM/WB pipeline register with stall, flush and load-miss wait FSM.
// Optional miss performance counters are built when MEM_WB_PERF_EN is defined.
module mem_wb_pipe_reg
  import mem_wb_pkg::*;
#(
  parameter int DATA_W       = DATA_W_DEF,
  parameter int REG_ADDR_W   = REG_ADDR_W_DEF,
  parameter int STAGES       = 1,
  parameter int MISS_LATENCY = 4
) (
  input  logic                  clockPulse,
  input  logic                  reset,
  input  logic                  valid_in,
  input  logic                  hit,
  input  logic [DATA_W-1:0]     read_data,
  input  logic [DATA_W-1:0]     alu_result,
  input  logic [REG_ADDR_W-1:0] write_reg,
  input  logic                  reg_write,
  input  logic                  mem_to_reg,
  input  logic                  stall,
  input  logic                  flush,
  output logic                  miss_stall,
  output logic                  valid_out,
  output logic                  hit_out,
  output logic [DATA_W-1:0]     read_data_out,
  output logic [DATA_W-1:0]     alu_result_out,
  output logic [REG_ADDR_W-1:0] write_reg_out,
  output logic                  reg_write_out,
  output logic                  mem_to_reg_out,
  output logic [DATA_W-1:0]     wb_data
`ifdef MEM_WB_PERF_EN
  ,
  output logic [31:0]           miss_count,
  output logic [31:0]           miss_cycles
`endif
);

  typedef struct packed {
    logic                  valid;
    logic                  hit;
    logic [DATA_W-1:0]     readData;
    logic [DATA_W-1:0]     aluResult;
    logic [REG_ADDR_W-1:0] writeReg;
    logic                  regWrite;
    logic                  memToReg;
  } slot_t;

  missState_t            state, stateNext;
  logic [MISS_CNT_W-1:0] missCnt, missCntNext;
  logic                  loadMiss, missReq, captureBubble, fillDone;
  slot_t                 capture;
  slot_t                 slotD [STAGES];
  slot_t                 slotQ [STAGES];

  // Stores never wait on a miss; only a valid load that misses does.
  assign loadMiss = valid_in & mem_to_reg & ~hit;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves a signal unassigned and no latch is inferred.
    stateNext     = state;
    missCntNext   = missCnt;
    missReq       = 1'b0;
    captureBubble = 1'b0;
    fillDone      = 1'b0;
    case (state)
      IDLE: begin
        if (loadMiss) begin
          missReq       = 1'b1;
          captureBubble = 1'b1;
          stateNext     = MISS_WAIT;
          missCntNext   = MISS_CNT_W'(MISS_LATENCY - 1);
        end
      end
      MISS_WAIT: begin
        if (missCnt == '0) begin
          fillDone  = 1'b1;
          stateNext = IDLE;
        end else begin
          missReq       = 1'b1;
          captureBubble = 1'b1;
          missCntNext   = missCnt - MISS_CNT_W'(1);
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clockPulse or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      missCnt <= '0;
    end else if (flush) begin
      state   <= IDLE;
      missCnt <= '0;
    end else if (!stall) begin
      state   <= stateNext;
      missCnt <= missCntNext;
    end
  end

  assign miss_stall = missReq & ~reset;

  // A completed fill is captured as a hit; writes to $zero never reach WB.
  always_comb begin
    capture.valid     = valid_in & ~captureBubble;
    capture.hit       = hit | fillDone;
    capture.readData  = read_data;
    capture.aluResult = alu_result;
    capture.writeReg  = write_reg;
    capture.regWrite  = reg_write & valid_in & (write_reg != '0) & ~captureBubble;
    capture.memToReg  = mem_to_reg;
  end

  assign slotD[0] = capture;
  for (genvar k = 1; k < STAGES; k++) begin : g_chain
    assign slotD[k] = slotQ[k-1];
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_slot
    mem_wb_slot #(.slot_t(slot_t)) u_slot (
      .clockPulse (clockPulse),
      .reset      (reset),
      .clear      (flush),
      .load       (!stall),
      .d          (slotD[k]),
      .q          (slotQ[k])
    );
  end

  assign valid_out      = slotQ[STAGES-1].valid;
  assign hit_out        = slotQ[STAGES-1].hit;
  assign read_data_out  = slotQ[STAGES-1].readData;
  assign alu_result_out = slotQ[STAGES-1].aluResult;
  assign write_reg_out  = slotQ[STAGES-1].writeReg;
  assign reg_write_out  = slotQ[STAGES-1].regWrite;
  assign mem_to_reg_out = slotQ[STAGES-1].memToReg;
  assign wb_data        = mem_to_reg_out ? read_data_out : alu_result_out;

`ifdef MEM_WB_PERF_EN
  // A flushed edge in MISS_WAIT still counts as a cycle spent waiting.
  always_ff @(posedge clockPulse or posedge reset) begin
    if (reset) begin
      miss_count  <= '0;
      miss_cycles <= '0;
    end else begin
      if (!flush && !stall && state == IDLE && loadMiss && miss_count != '1)
        miss_count <= miss_count + 32'd1;
      if (state == MISS_WAIT && (flush || !stall) && miss_cycles != '1)
        miss_cycles <= miss_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_wb_pipe_reg.sv
// Self-checking bench: three configurations driven in parallel against a queue-style model.
`timescale 1ns/1ps
module tb_mem_wb_pipe_reg;

  localparam int DW   = 32;
  localparam int AW   = 5;
  localparam int NDUT = 3;
  localparam int STG [NDUT] = '{1, 3, 1};
  localparam int LAT [NDUT] = '{4, 4, 1};

  logic          clockPulse = 1'b0;
  logic          reset;
  logic          valid_in, hit, reg_write, mem_to_reg, stall, flush;
  logic [DW-1:0] read_data, alu_result;
  logic [AW-1:0] write_reg;

  logic          missStall [NDUT];
  logic          vOut      [NDUT];
  logic          hOut      [NDUT];
  logic          rwOut     [NDUT];
  logic          m2rOut    [NDUT];
  logic [DW-1:0] rdOut     [NDUT];
  logic [DW-1:0] aluOut    [NDUT];
  logic [DW-1:0] wbOut     [NDUT];
  logic [AW-1:0] wrOut     [NDUT];
  logic [31:0]   mcOut     [NDUT];
  logic [31:0]   mcyOut    [NDUT];

  int checks = 0;
  int errors = 0;

  always #250 clockPulse = ~clockPulse;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    mem_wb_pipe_reg #(
      .DATA_W(DW), .REG_ADDR_W(AW), .STAGES(STG[g]), .MISS_LATENCY(LAT[g])
    ) u_dut (
      .clockPulse     (clockPulse),
      .reset          (reset),
      .valid_in       (valid_in),
      .hit            (hit),
      .read_data      (read_data),
      .alu_result     (alu_result),
      .write_reg      (write_reg),
      .reg_write      (reg_write),
      .mem_to_reg     (mem_to_reg),
      .stall          (stall),
      .flush          (flush),
      .miss_stall     (missStall[g]),
      .valid_out      (vOut[g]),
      .hit_out        (hOut[g]),
      .read_data_out  (rdOut[g]),
      .alu_result_out (aluOut[g]),
      .write_reg_out  (wrOut[g]),
      .reg_write_out  (rwOut[g]),
      .mem_to_reg_out (m2rOut[g]),
      .wb_data        (wbOut[g])
`ifdef MEM_WB_PERF_EN
      ,
      .miss_count     (mcOut[g]),
      .miss_cycles    (mcyOut[g])
`endif
    );
  end

`ifndef MEM_WB_PERF_EN
  for (genvar g = 0; g < NDUT; g++) begin : g_noperf
    assign mcOut[g]  = '0;
    assign mcyOut[g] = '0;
  end
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a shift array of entries per configuration plus a "cycles left" miss timer.
  typedef struct {
    bit          valid;
    bit          hit;
    bit [DW-1:0] rd;
    bit [DW-1:0] alu;
    bit [AW-1:0] wr;
    bit          rw;
    bit          m2r;
  } ent_t;

  ent_t      pipe    [NDUT][4];
  bit        waiting [NDUT];
  int        left    [NDUT];
  bit [31:0] mCount  [NDUT];
  bit [31:0] mCycles [NDUT];

  task automatic modelEdge();
    for (int d = 0; d < NDUT; d++) begin
      ent_t n;
      n.valid = valid_in;
      n.hit   = hit;
      n.rd    = read_data;
      n.alu   = alu_result;
      n.wr    = write_reg;
      n.rw    = reg_write && valid_in && (write_reg != 0);
      n.m2r   = mem_to_reg;
      if (reset) begin
        for (int k = 0; k < 4; k++) pipe[d][k] = '{default: 0};
        waiting[d] = 0;
        left[d]    = 0;
        mCount[d]  = 0;
        mCycles[d] = 0;
      end else if (flush) begin
        if (waiting[d] && mCycles[d] != 32'hFFFF_FFFF) mCycles[d]++;
        for (int k = 0; k < 4; k++) begin
          pipe[d][k].valid = 0;
          pipe[d][k].rw    = 0;
        end
        waiting[d] = 0;
        left[d]    = 0;
      end else if (!stall) begin
        if (waiting[d]) begin
          if (mCycles[d] != 32'hFFFF_FFFF) mCycles[d]++;
          if (left[d] == 0) begin
            n.hit      = 1;
            waiting[d] = 0;
          end else begin
            left[d]--;
            n.valid = 0;
            n.rw    = 0;
          end
        end else if (valid_in && mem_to_reg && !hit) begin
          waiting[d] = 1;
          left[d]    = LAT[d] - 1;
          if (mCount[d] != 32'hFFFF_FFFF) mCount[d]++;
          n.valid = 0;
          n.rw    = 0;
        end
        for (int k = 3; k > 0; k--) pipe[d][k] = pipe[d][k-1];
        pipe[d][0] = n;
      end
    end
  endtask

  function automatic bit expMiss(int d);
    if (reset) return 0;
    if (waiting[d]) return left[d] != 0;
    return valid_in && mem_to_reg && !hit;
  endfunction

  task automatic compareAll();
    for (int d = 0; d < NDUT; d++) begin
      ent_t e;
      e = pipe[d][STG[d]-1];
      check($sformatf("d%0d valid_out", d), 32'(vOut[d]), 32'(e.valid));
      check($sformatf("d%0d reg_write_out", d), 32'(rwOut[d]), 32'(e.rw));
      check($sformatf("d%0d miss_stall", d), 32'(missStall[d]), 32'(expMiss(d)));
      if (e.valid) begin
        check($sformatf("d%0d hit_out", d), 32'(hOut[d]), 32'(e.hit));
        check($sformatf("d%0d read_data_out", d), rdOut[d], e.rd);
        check($sformatf("d%0d alu_result_out", d), aluOut[d], e.alu);
        check($sformatf("d%0d write_reg_out", d), 32'(wrOut[d]), 32'(e.wr));
        check($sformatf("d%0d mem_to_reg_out", d), 32'(m2rOut[d]), 32'(e.m2r));
        check($sformatf("d%0d wb_data", d), wbOut[d], e.m2r ? e.rd : e.alu);
      end
`ifdef MEM_WB_PERF_EN
      check($sformatf("d%0d miss_count", d), mcOut[d], mCount[d]);
      check($sformatf("d%0d miss_cycles", d), mcyOut[d], mCycles[d]);
`endif
    end
  endtask

  initial forever begin
    @(posedge clockPulse or posedge reset);
    modelEdge();
  end

  initial forever begin
    @(negedge clockPulse);
    compareAll();
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish at %0t", $time);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clockPulse);
    #1;
  endtask

  task automatic setIn(input logic v, input logic h, input logic [DW-1:0] rd,
                       input logic [DW-1:0] alu, input logic [AW-1:0] wr,
                       input logic rw, input logic m2r);
    valid_in   = v;
    hit        = h;
    read_data  = rd;
    alu_result = alu;
    write_reg  = wr;
    reg_write  = rw;
    mem_to_reg = m2r;
  endtask

  initial begin
    int cnt;
    reset = 1'b1;
    stall = 1'b0;
    flush = 1'b0;
    setIn(0, 0, '0, '0, '0, 0, 0);
    repeat (2) @(posedge clockPulse);
    #1;
    for (int d = 0; d < 2; d++) begin
      check("reset valid_out", 32'(vOut[d]), 0);
      check("reset hit_out", 32'(hOut[d]), 0);
      check("reset read_data_out", rdOut[d], 0);
      check("reset alu_result_out", aluOut[d], 0);
      check("reset write_reg_out", 32'(wrOut[d]), 0);
      check("reset reg_write_out", 32'(rwOut[d]), 0);
      check("reset mem_to_reg_out", 32'(m2rOut[d]), 0);
      check("reset wb_data", wbOut[d], 0);
      check("reset miss_stall", 32'(missStall[d]), 0);
    end
    reset = 1'b0;

    // Hit path, ALU writeback.
    setIn(1, 1, 32'h14, 32'd16, 5'd3, 1, 0);
    tick();
    check("hit valid_out", 32'(vOut[0]), 1);
    check("hit reg_write_out", 32'(rwOut[0]), 1);
    check("hit wb_data", wbOut[0], 32'd16);

    // Load hit to $zero: data selected, write suppressed.
    setIn(1, 1, 32'h0E, 32'h40, 5'd0, 1, 1);
    tick();
    check("load wb_data", wbOut[0], 32'h0E);
    check("zero reg_write_out", 32'(rwOut[0]), 0);

    // Store with hit=0 must not wait.
    setIn(1, 0, 32'h55, 32'h77, 5'd7, 0, 0);
    #1;
    check("store miss_stall", 32'(missStall[0]), 0);
    tick();
    check("store valid_out", 32'(vOut[0]), 1);
    check("store wb_data", wbOut[0], 32'h77);

    setIn(0, 0, '0, '0, '0, 0, 0);
    repeat (3) tick();

    // Load miss, latency 4.
    setIn(1, 0, 32'hABCD, 32'h100, 5'd5, 1, 1);
    #1;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (!missStall[0]) break;
      cnt++;
      check("miss valid_out low", 32'(vOut[0]), 0);
      tick();
    end
    check("miss stall cycles", cnt, 4);
    tick();
    check("fill valid_out", 32'(vOut[0]), 1);
    check("fill hit_out", 32'(hOut[0]), 1);
    check("fill wb_data", wbOut[0], 32'hABCD);
    setIn(0, 0, '0, '0, '0, 0, 0);
    tick();

    // Load miss with a 3-cycle external stall inside MISS_WAIT.
    setIn(1, 0, 32'h1234, 32'h200, 5'd6, 1, 1);
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      stall = (i >= 2 && i < 5);
      #1;
      if (!missStall[0] && i >= 5) break;
      if (missStall[0]) cnt++;
      tick();
    end
    stall = 1'b0;
    check("stalled miss stall cycles", cnt, 7);
    tick();
    check("stalled fill valid_out", 32'(vOut[0]), 1);
    check("stalled fill read_data_out", rdOut[0], 32'h1234);
`ifdef MEM_WB_PERF_EN
    check("perf miss_count", mcOut[0], 2);
    check("perf miss_cycles", mcyOut[0], 8);
`endif
    setIn(0, 0, '0, '0, '0, 0, 0);
    tick();

    // Flush on the second MISS_WAIT cycle, then a normal hit.
    setIn(1, 0, 32'h9999, 32'h300, 5'd8, 1, 1);
    tick();
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    setIn(1, 1, 32'h0, 32'h42, 5'd9, 1, 0);
    #1;
    check("flush miss_stall", 32'(missStall[0]), 0);
    check("flush valid_out", 32'(vOut[0]), 0);
    check("flush reg_write_out", 32'(rwOut[0]), 0);
    tick();
    check("post-flush valid_out", 32'(vOut[0]), 1);
    check("post-flush wb_data", wbOut[0], 32'h42);

    // Three-stage latency.
    setIn(0, 0, '0, '0, '0, 0, 0);
    repeat (3) tick();
    setIn(1, 1, 32'h0, 32'd1, 5'd1, 1, 0);
    tick();
    setIn(1, 1, 32'h0, 32'd2, 5'd1, 1, 0);
    tick();
    setIn(1, 1, 32'h0, 32'd3, 5'd1, 1, 0);
    tick();
    check("stages3 edge3 wb_data", wbOut[1], 32'd1);
    setIn(0, 0, '0, '0, '0, 0, 0);
    tick();
    check("stages3 edge4 wb_data", wbOut[1], 32'd2);
    tick();
    check("stages3 edge5 wb_data", wbOut[1], 32'd3);

    // Latency-1 miss: exactly one bubble.
    setIn(1, 0, 32'hBEEF, 32'h500, 5'd10, 1, 1);
    #1;
    check("lat1 miss_stall first", 32'(missStall[2]), 1);
    tick();
    check("lat1 miss_stall second", 32'(missStall[2]), 0);
    check("lat1 bubble valid_out", 32'(vOut[2]), 0);
    tick();
    check("lat1 fill valid_out", 32'(vOut[2]), 1);
    check("lat1 fill hit_out", 32'(hOut[2]), 1);
    check("lat1 fill read_data_out", rdOut[2], 32'hBEEF);
    setIn(0, 0, '0, '0, '0, 0, 0);
    repeat (8) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_wb_pipe_reg.md
Name: mem_wb_pipe_reg

Overview:
Parametrised MEM/WB pipeline register for the MIPS datapath, replacing the fixed single-stage 32-bit MEM/WB register.
- Widths and depth are configurable.
- Adds valid tracking, external stall and flush, and a cache-miss wait state machine.
- Produces the writeback-data mux output, so the WB stage only consumes registered values.
- Sits between the data-cache/MEM stage and the register-file write port.

Parameters:
DATA_W, 32, width of read data, ALU result and writeback data
REG_ADDR_W, 5, register-file address width
STAGES, 1, number of register slots between MEM and WB (1..4)
MISS_LATENCY, 4, cycles held in MISS_WAIT for a load miss (1..255)

Ports:
clockPulse  in  1  pipeline clock, rising-edge
reset  in  1  asynchronous, active-high reset
valid_in  in  1  MEM-stage instruction valid
hit  in  1  data-cache hit for current access
read_data  in  DATA_W  data-memory read data
alu_result  in  DATA_W  ALU result / address
write_reg  in  REG_ADDR_W  destination register
reg_write  in  1  register-file write enable
mem_to_reg  in  1  1 = writeback selects read_data
stall  in  1  external freeze of all slots and the FSM
flush  in  1  squash all slots
miss_stall  out  1  request to upstream to hold MEM inputs stable
valid_out  out  1  WB valid
hit_out  out  1  registered hit
read_data_out  out  DATA_W  registered read data
alu_result_out  out  DATA_W  registered ALU result
write_reg_out  out  REG_ADDR_W  registered destination
reg_write_out  out  1  registered write enable, qualified
mem_to_reg_out  out  1  registered select
wb_data  out  DATA_W  mem_to_reg_out ? read_data_out : alu_result_out

Behaviour:
- Clock and reset:
  - Single clock, clockPulse.
  - reset is asynchronous and active-high.
  - Reset state: all outputs 0, all slots invalid, FSM IDLE, miss counter 0.
- Precedence per edge: reset > flush > stall > miss FSM > normal advance.
- Latency: STAGES cycles from an accepted MEM entry to WB outputs; slot k loads slot k-1 each edge.
- Qualification at capture:
  - reg_write_out = reg_write & valid_in & (write_reg != 0); writes to $zero are suppressed.
  - Invalid slots carry reg_write = 0.
- FSM IDLE:
  - valid_in & mem_to_reg & !hit (load miss) -> MISS_WAIT, counter = MISS_LATENCY-1, miss_stall = 1 combinationally this cycle.
  - Slot 0 captures a bubble (valid 0, reg_write 0).
  - Any other case: capture inputs normally.
- FSM MISS_WAIT:
  - miss_stall = 1; slot 0 captures bubbles; downstream slots keep advancing (draining).
  - Counter decrements each non-stalled edge.
  - At counter 0: capture the held inputs with hit_out forced to 1 (fill complete), then return to IDLE with miss_stall = 0.
  - MISS_LATENCY = 1 gives exactly one bubble.
- Stores (mem_to_reg = 0) never enter MISS_WAIT regardless of hit.
- stall = 1: every slot, the FSM state and the counter hold; outputs unchanged; miss_stall holds its value.
- flush = 1:
  - All slots are cleared to invalid with reg_write 0 on that edge (data fields may hold).
  - FSM returns to IDLE with counter 0; miss_stall drops next cycle.
  - Flush during MISS_WAIT aborts the miss.
- Simultaneous flush and stall: flush wins.
- Reset asserted mid-MISS_WAIT: immediate return to the reset state, no edge required.
- wb_data is combinational from registered outputs only; there is no input-to-output path.

Optional Feature:
MEM_WB_PERF_EN
- Defined:
  - Adds outputs miss_count [31:0], incremented on each IDLE->MISS_WAIT transition.
  - Adds outputs miss_cycles [31:0], incremented on each non-stalled edge spent in MISS_WAIT.
  - Both counters saturate at all-ones and clear on reset only; flush does not clear them.
- Undefined: neither port nor the counters exist; behaviour is otherwise identical.

Decomposition:
- Package mem_wb_pkg:
  - FSM state enum (IDLE, MISS_WAIT).
  - Default width constants DATA_W_DEF = 32 and REG_ADDR_W_DEF = 5.
  - Slot record typedef: valid, hit, read_data, alu_result, write_reg, reg_write, mem_to_reg.
- Sub-module mem_wb_slot: one slot register with async reset, hold (stall), clear (flush) and load; instantiated STAGES times in a generate loop.
- FSM and counter stay in the top.

Test Plan:
- Reset then hit path, STAGES = 1, period 500 ns: valid_in = 1, hit = 1, read_data = 0x14, alu_result = 16, write_reg = 3, reg_write = 1, mem_to_reg = 0 -> after 1 edge: valid_out = 1, reg_write_out = 1, wb_data = 16.
- Load hit with mem_to_reg = 1, read_data = 0x0E -> wb_data = 0x0E; write_reg = 0 with reg_write = 1 -> reg_write_out = 0.
- Load miss, MISS_LATENCY = 4, hit = 0:
  - miss_stall is high for exactly 4 cycles and valid_out = 0 meanwhile.
  - On the 5th cycle valid_out = 1 and hit_out = 1 with the held read_data.
- Stall = 1 for 3 cycles inside MISS_WAIT -> miss_stall is high for 7 cycles total and outputs are frozen while stalled.
- Flush on the 2nd MISS_WAIT cycle -> next cycle miss_stall = 0, FSM IDLE, valid_out = 0; a subsequent hit proceeds normally.
- STAGES = 3: a back-to-back sequence of alu_result 1, 2, 3 appears at wb_data on edges 3, 4, 5. With MEM_WB_PERF_EN, two misses of latency 4 -> miss_count = 2, miss_cycles = 8.
